timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 26, sets the counter, period register and PERIOD/COUNT port width.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RESET  input  1  reset, asynchronous, active-high.
REQ-004 START  input  1  begin or restart a timing run; sampled each edge.
REQ-005 STOP  input  1  abort the run; sampled each edge.
REQ-006 PERIODIC  input  1  mode select, captured on an accepted START: 1 = auto-reload, 0 = one-shot.
REQ-007 LOAD  input  1  write PERIOD into the period register.
REQ-008 PERIOD  input  WIDTH  terminal count value.
REQ-009 COUNT  output  WIDTH  current counter value, registered.
REQ-010 TICK  output  1  one-cycle registered pulse per expiry.
REQ-011 BUSY  output  1  high while the state is RUN.
REQ-012 DONE  output  1  high while the state is EXPIRED.

Function
REQ-013 State machine SHALL have three states: IDLE, RUN and EXPIRED; the encoding is free.
REQ-014 Priority at each edge SHALL be STOP > START > terminal event > increment.
REQ-015 STOP in any state SHALL move the FSM to IDLE and freeze COUNT at its current value; TICK is 0 on the next cycle.
REQ-016 START with STOP low, in any state, SHALL clear COUNT to 0, capture PERIODIC into the mode bit and enter RUN; a START in RUN restarts the run without a TICK.
REQ-017 In RUN, with no STOP or START, each edge SHALL increment COUNT by 1 (modulo 2^WIDTH) unless the terminal condition holds.
REQ-018 The terminal condition is COUNT >= period_reg (unsigned); on that edge COUNT <= 0 and TICK <= 1 for exactly one cycle.
REQ-019 On a terminal event: if mode = 1 the FSM SHALL stay in RUN; if mode = 0 it SHALL enter EXPIRED.
REQ-020 The expiry interval is period_reg+1 cycles; period_reg = 0 in periodic mode SHALL give TICK high on every cycle after the first.
REQ-021 LOAD SHALL update period_reg on the same edge in any state, without disturbing COUNT or the FSM state.
REQ-022 When LOAD coincides with a terminal evaluation, that evaluation SHALL use the old period_reg.
REQ-023 If LOAD lowers period_reg below the current COUNT, the next RUN edge SHALL be a terminal event (no wrap through 2^WIDTH).
REQ-024 In EXPIRED, COUNT SHALL hold 0 and TICK 0 until START or STOP.
REQ-025 BUSY and DONE SHALL be decoded from the state register only (glitch-free, no input paths).
REQ-026 The counter SHALL be a single WIDTH-bit incrementer; the carry-out is unused and no output depends combinationally on any input.

Reset
REQ-027 RESET high SHALL immediately force: state IDLE, COUNT = 0, TICK = 0, mode = 0, period_reg = 2^WIDTH-1.
REQ-028 RESET asserted mid-run SHALL abort the run without a TICK; after release the block waits in IDLE for START.
REQ-029 The first edge after RESET deasserts SHALL operate normally (no dead cycle).

Verification
REQ-030 One-shot: LOAD PERIOD=3, START with PERIODIC=0 -> COUNT 0,1,2,3,0; single TICK on the cycle COUNT returns to 0; DONE=1, BUSY=0 thereafter.
REQ-031 Periodic: PERIOD=4, START with PERIODIC=1, run 20 cycles -> exactly 4 TICKs, 5 cycles apart; BUSY stays 1.
REQ-032 Simultaneous events: STOP+START together in RUN at COUNT=2 -> IDLE, COUNT frozen at 2, no TICK; then START alone -> COUNT=0, RUN.
REQ-033 Period shrink: PERIOD=10, RUN to COUNT=7, LOAD PERIOD=5 -> next edge terminal: TICK=1, COUNT=0; subsequent interval is 6 cycles.
REQ-034 Zero period: LOAD 0, START periodic -> TICK high every cycle after the first; COUNT stays 0.
REQ-035 Async reset: RESET pulsed between edges at COUNT=5 -> outputs 0 immediately; period_reg = all ones (verified by START with no LOAD: no TICK within 100 cycles, COUNT=100).

Source files
------------

// File: rtl/timer_ctrl.sv
// Programmable up-counter timer with one-shot/auto-reload modes; COUNT/TICK registered (1-cycle latency from edge).
// No backpressure: STOP > START > terminal > increment each edge; LOAD updates the period in any state.
module timer_ctrl #(
  parameter int WIDTH = 26
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             STOP,
  input  logic             PERIODIC,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] COUNT,
  output logic             TICK,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  logic             mode;
  logic [WIDTH-1:0] period_reg;
  logic [WIDTH-1:0] count;
  logic             tick;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      mode       <= 1'b0;
      period_reg <= '1;
      count      <= '0;
      tick       <= 1'b0;
    end else begin
      // period_reg is read below before this update takes effect, so a
      // coincident terminal check always sees the old period.
      if (LOAD)
        period_reg <= PERIOD;
      tick <= 1'b0;
      if (STOP) begin
        state <= IDLE;
      end else if (START) begin
        count <= '0;
        mode  <= PERIODIC;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            // >= rather than == so a shrunk period terminates at once
            // instead of wrapping through 2^WIDTH.
            if (count >= period_reg) begin
              count <= '0;
              tick  <= 1'b1;
              if (!mode)
                state <= EXPIRED;
            end else begin
              count <= count + WIDTH'(1);
            end
          end
          EXPIRED: count <= '0;
          default: ;
        endcase
      end
    end
  end

  assign COUNT = count;
  assign TICK  = tick;
  assign BUSY  = (state == RUN);
  assign DONE  = (state == EXPIRED);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl: one task per scenario.
module tb_timer_ctrl;

  localparam int W = 26;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         periodic;
  logic         load;
  logic [W-1:0] period;
  logic [W-1:0] count;
  logic         tick;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .START    (start),
    .STOP     (stop),
    .PERIODIC (periodic),
    .LOAD     (load),
    .PERIOD   (period),
    .COUNT    (count),
    .TICK     (tick),
    .BUSY     (busy),
    .DONE     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge; sampling and driving happen 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count !== '0 || tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL reset_outputs: count=%0d tick=%b busy=%b done=%b, want 0 0 0 0", count, tick, busy, done);
      errors++;
    end
    #2 rst = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || count !== '0) begin
      $display("FAIL reset_idle: busy=%b count=%0d, want 0 0", busy, count);
      errors++;
    end
  endtask

  task automatic test_oneshot();
    load = 1'b1; period = W'(3);
    cyc();
    load = 1'b0;
    start = 1'b1; periodic = 1'b0;
    cyc();
    start = 1'b0;
    checks++;
    if (count !== W'(0) || busy !== 1'b1 || tick !== 1'b0) begin
      $display("FAIL oneshot_start: count=%0d busy=%b tick=%b, want 0 1 0", count, busy, tick);
      errors++;
    end
    for (int i = 1; i <= 3; i++) begin
      cyc();
      checks++;
      if (count !== W'(i) || tick !== 1'b0) begin
        $display("FAIL oneshot_count%0d: count=%0d tick=%b, want %0d 0", i, count, tick, i);
        errors++;
      end
    end
    cyc();
    checks++;
    if (count !== W'(0) || tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL oneshot_expire: count=%0d tick=%b done=%b busy=%b, want 0 1 1 0", count, tick, done, busy);
      errors++;
    end
    cyc();
    checks++;
    if (count !== W'(0) || tick !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL oneshot_hold: count=%0d tick=%b done=%b busy=%b, want 0 0 1 0", count, tick, done, busy);
      errors++;
    end
  endtask

  task automatic test_periodic();
    int nticks;
    nticks = 0;
    load = 1'b1; period = W'(4);
    start = 1'b1; periodic = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (tick === 1'b1) nticks++;
      checks++;
      if (tick !== ((i % 5) == 0) || busy !== 1'b1) begin
        $display("FAIL periodic_cyc%0d: tick=%b busy=%b, want %b 1", i, tick, busy, (i % 5) == 0);
        errors++;
      end
    end
    checks++;
    if (nticks != 4) begin
      $display("FAIL periodic_ticks: got %0d, want 4", nticks);
      errors++;
    end
  endtask

  task automatic test_simultaneous();
    start = 1'b1; periodic = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    checks++;
    if (count !== W'(2)) begin
      $display("FAIL simul_pre: count=%0d, want 2", count);
      errors++;
    end
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    checks++;
    if (count !== W'(2) || busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
      $display("FAIL simul_stop: count=%0d busy=%b done=%b tick=%b, want 2 0 0 0", count, busy, done, tick);
      errors++;
    end
    cyc();
    checks++;
    if (count !== W'(2) || busy !== 1'b0) begin
      $display("FAIL simul_frozen: count=%0d busy=%b, want 2 0", count, busy);
      errors++;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (count !== W'(0) || busy !== 1'b1) begin
      $display("FAIL simul_restart: count=%0d busy=%b, want 0 1", count, busy);
      errors++;
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_shrink();
    load = 1'b1; period = W'(10);
    start = 1'b1; periodic = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    load = 1'b1; period = W'(5);
    cyc();
    load = 1'b0;
    checks++;
    if (count !== W'(7) || tick !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL shrink_load: count=%0d tick=%b busy=%b, want 7 0 1", count, tick, busy);
      errors++;
    end
    cyc();
    checks++;
    if (count !== W'(0) || tick !== 1'b1) begin
      $display("FAIL shrink_term: count=%0d tick=%b, want 0 1", count, tick);
      errors++;
    end
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checks++;
      if (tick !== (i == 6) || count !== ((i == 6) ? W'(0) : W'(i))) begin
        $display("FAIL shrink_int%0d: count=%0d tick=%b, want %0d %b", i, count, tick, (i == 6) ? 0 : i, i == 6);
        errors++;
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_load_old_period();
    load = 1'b1; period = W'(2);
    start = 1'b1; periodic = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    cyc();
    cyc();
    load = 1'b1; period = W'(20);
    cyc();
    load = 1'b0;
    checks++;
    if (count !== W'(0) || tick !== 1'b1) begin
      $display("FAIL load_old_period: count=%0d tick=%b, want 0 1", count, tick);
      errors++;
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_zero_period();
    load = 1'b1; period = W'(0);
    start = 1'b1; periodic = 1'b1;
    cyc();
    load = 1'b0; start = 1'b0;
    checks++;
    if (count !== W'(0) || tick !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL zero_first: count=%0d tick=%b busy=%b, want 0 0 1", count, tick, busy);
      errors++;
    end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++;
      if (count !== W'(0) || tick !== 1'b1 || busy !== 1'b1) begin
        $display("FAIL zero_cyc%0d: count=%0d tick=%b busy=%b, want 0 1 1", i, count, tick, busy);
        errors++;
      end
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL zero_stop: tick=%b busy=%b, want 0 0", tick, busy);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    int tick_seen;
    tick_seen = 0;
    load = 1'b1; period = W'(50);
    start = 1'b1; periodic = 1'b0;
    cyc();
    load = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (count !== W'(5)) begin
      $display("FAIL areset_pre: count=%0d, want 5", count);
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== W'(0) || tick !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL areset_now: count=%0d tick=%b busy=%b done=%b, want 0 0 0 0", count, tick, busy, done);
      errors++;
    end
    #1 rst = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0 || count !== W'(0) || tick !== 1'b0) begin
      $display("FAIL areset_idle: busy=%b count=%0d tick=%b, want 0 0 0", busy, count, tick);
      errors++;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (tick === 1'b1) tick_seen++;
    end
    checks++;
    if (tick_seen != 0 || count !== W'(100) || busy !== 1'b1) begin
      $display("FAIL areset_period: ticks=%0d count=%0d busy=%b, want 0 100 1", tick_seen, count, busy);
      errors++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0;
    load = 1'b0; period = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_simultaneous();
    test_shrink();
    test_load_old_period();
    test_zero_period();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
